// File: rtl/seg14_pkg.sv
// Shared types, constants and the character-to-segment table for the
// 12-digit, 14-segment banner display scan controller.
package seg14_pkg;

   localparam int CHAR_W = 6;
   localparam int SEG_W  = 14;
   localparam int ADDR_W = 4;

   // Character codes: 0 is space, 1..26 are letters, 27..36 are digits.
   localparam logic [CHAR_W-1:0] CH_SPACE = 6'd0;
   localparam logic [CHAR_W-1:0] CH_A = 6'd1;
   localparam logic [CHAR_W-1:0] CH_B = 6'd2;
   localparam logic [CHAR_W-1:0] CH_C = 6'd3;
   localparam logic [CHAR_W-1:0] CH_D = 6'd4;
   localparam logic [CHAR_W-1:0] CH_E = 6'd5;
   localparam logic [CHAR_W-1:0] CH_F = 6'd6;
   localparam logic [CHAR_W-1:0] CH_G = 6'd7;
   localparam logic [CHAR_W-1:0] CH_H = 6'd8;
   localparam logic [CHAR_W-1:0] CH_I = 6'd9;
   localparam logic [CHAR_W-1:0] CH_J = 6'd10;
   localparam logic [CHAR_W-1:0] CH_K = 6'd11;
   localparam logic [CHAR_W-1:0] CH_L = 6'd12;
   localparam logic [CHAR_W-1:0] CH_M = 6'd13;
   localparam logic [CHAR_W-1:0] CH_N = 6'd14;
   localparam logic [CHAR_W-1:0] CH_O = 6'd15;
   localparam logic [CHAR_W-1:0] CH_P = 6'd16;
   localparam logic [CHAR_W-1:0] CH_Q = 6'd17;
   localparam logic [CHAR_W-1:0] CH_R = 6'd18;
   localparam logic [CHAR_W-1:0] CH_S = 6'd19;
   localparam logic [CHAR_W-1:0] CH_T = 6'd20;
   localparam logic [CHAR_W-1:0] CH_U = 6'd21;
   localparam logic [CHAR_W-1:0] CH_V = 6'd22;
   localparam logic [CHAR_W-1:0] CH_W = 6'd23;
   localparam logic [CHAR_W-1:0] CH_X = 6'd24;
   localparam logic [CHAR_W-1:0] CH_Y = 6'd25;
   localparam logic [CHAR_W-1:0] CH_Z = 6'd26;
   localparam logic [CHAR_W-1:0] CH_0 = 6'd27;
   localparam logic [CHAR_W-1:0] CH_1 = 6'd28;
   localparam logic [CHAR_W-1:0] CH_2 = 6'd29;
   localparam logic [CHAR_W-1:0] CH_3 = 6'd30;
   localparam logic [CHAR_W-1:0] CH_4 = 6'd31;
   localparam logic [CHAR_W-1:0] CH_5 = 6'd32;
   localparam logic [CHAR_W-1:0] CH_6 = 6'd33;
   localparam logic [CHAR_W-1:0] CH_7 = 6'd34;
   localparam logic [CHAR_W-1:0] CH_8 = 6'd35;
   localparam logic [CHAR_W-1:0] CH_9 = 6'd36;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   // Segment order, MSB first: a b c d e f g1 g2 h i j k l m.
   // Codes without an entry (space and 37..63) render blank.
   function automatic logic [SEG_W-1:0] glyph14(input logic [CHAR_W-1:0] code);
      logic [SEG_W-1:0] g;
      g = '0;
      case (code)
         CH_A: g = 14'b11101111000000;
         CH_B: g = 14'b11110001010010;
         CH_C: g = 14'b10011100000000;
         CH_D: g = 14'b11110000010010;
         CH_E: g = 14'b10011110000000;
         CH_F: g = 14'b10001110000000;
         CH_G: g = 14'b10111101000000;
         CH_H: g = 14'b01101111000000;
         CH_I: g = 14'b10010000010010;
         CH_J: g = 14'b01111000000000;
         CH_K: g = 14'b00001110001100;
         CH_L: g = 14'b00011100000000;
         CH_M: g = 14'b01101100101000;
         CH_N: g = 14'b01101100100100;
         CH_O: g = 14'b11111100000000;
         CH_P: g = 14'b11001111000000;
         CH_Q: g = 14'b11111100000100;
         CH_R: g = 14'b11001111000100;
         CH_S: g = 14'b10110111000000;
         CH_T: g = 14'b10000000010010;
         CH_U: g = 14'b01111100000000;
         CH_V: g = 14'b00001100001001;
         CH_W: g = 14'b01101100000101;
         CH_X: g = 14'b00000000101101;
         CH_Y: g = 14'b00000000101010;
         CH_Z: g = 14'b10010000001001;
         CH_0: g = 14'b11111100001001;
         CH_1: g = 14'b01100000001000;
         CH_2: g = 14'b11011011000000;
         CH_3: g = 14'b11110001000000;
         CH_4: g = 14'b01100111000000;
         CH_5: g = 14'b10010110000100;
         CH_6: g = 14'b10111111000000;
         CH_7: g = 14'b11100000000000;
         CH_8: g = 14'b11111111000000;
         CH_9: g = 14'b11110111000000;
         default: g = '0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg14_scan_ctrl_if.sv
// Host write port of the scan controller: valid/ready handshake carrying a
// buffer slot address and a character code, plus a bad-address error pulse.
interface seg14_scan_ctrl_if;
   import seg14_pkg::*;

   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [CHAR_W-1:0] wr_char;
   logic              wr_err;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_char,
      input  wr_ready,
      input  wr_err
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_char,
      output wr_ready,
      output wr_err
   );

endinterface

// File: rtl/seg14_char_buf.sv
// Character buffer: one register per display slot, one write port and one
// combinational read port. Every slot returns to space on reset.
module seg14_char_buf
   import seg14_pkg::*;
#(
   parameter int DEPTH = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [CHAR_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [CHAR_W-1:0] rdata
);

   logic [CHAR_W-1:0] mem [DEPTH];

   // Store a character; addresses beyond the last slot leave the buffer untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= CH_SPACE;
         end
      end else if (we && (int'(waddr) < DEPTH)) begin
         mem[waddr] <= wdata;
      end
   end

   // Read the addressed slot; out-of-range reads return space.
   always_comb begin
      rdata = CH_SPACE;
      if (int'(raddr) < DEPTH) begin
         rdata = mem[raddr];
      end
   end

endmodule

// File: rtl/seg14_scan_ctrl.sv
// Multiplexed refresh controller for a 12-digit 14-segment display.
// Each digit gets a one-cycle blanking gap followed by a programmable dwell;
// the character is fetched during the gap so a digit never changes mid-dwell.
// Optional scrolling rotates the buffer by one slot every SCROLL_FRAMES frames.
module seg14_scan_ctrl
   import seg14_pkg::*;
#(
   parameter int NUM_DIGITS    = 12,
   parameter int DWELL_W       = 16,
   parameter int SCROLL_FRAMES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DWELL_W-1:0]    dwell_cfg,
   seg14_scan_ctrl_if.slave      wr,
   input  logic                  scroll_en,
   output logic [NUM_DIGITS-1:0] sel,
   output logic [SEG_W-1:0]      segm,
   output logic                  frame_tick
);

   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_DIGITS - 1);
   localparam logic [ADDR_W:0]   DIGITS_EXT = (ADDR_W+1)'(NUM_DIGITS);
   localparam logic [7:0]        FRAME_LAST = 8'(SCROLL_FRAMES - 1);

   scan_state_t        state;
   scan_state_t        next_state;
   logic [ADDR_W-1:0]  idx;
   logic [ADDR_W-1:0]  offset;
   logic [7:0]         frame_cnt;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [DWELL_W-1:0] dwell_load;
   logic               show_last;
   logic               ready;
   logic               tick;
   logic               accept;
   logic               addr_bad;
   logic               err;
   logic [ADDR_W:0]    addr_sum;
   logic [ADDR_W-1:0]  rd_addr;
   logic [CHAR_W-1:0]  rd_char;

   // A zero dwell is stretched to one cycle so every digit is lit at least once.
   assign dwell_load = (dwell_cfg == '0) ? '0 : dwell_cfg - DWELL_W'(1);

   assign accept   = wr.wr_valid && ready;
   assign addr_bad = (wr.wr_addr > LAST_IDX);

   assign wr.wr_ready = ready;
   assign wr.wr_err   = err;
   assign frame_tick  = tick;

   // Buffer slot for the digit about to be shown: (idx + offset) mod NUM_DIGITS.
   always_comb begin
      addr_sum = {1'b0, idx} + {1'b0, offset};
      if (addr_sum >= DIGITS_EXT) begin
         addr_sum = addr_sum - DIGITS_EXT;
      end
      rd_addr = addr_sum[ADDR_W-1:0];
   end

   seg14_char_buf #(
      .DEPTH (NUM_DIGITS)
   ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept && !addr_bad),
      .waddr (wr.wr_addr),
      .wdata (wr.wr_char),
      .raddr (rd_addr),
      .rdata (rd_char)
   );

   // Scan state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BLANK;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake/tick decode; writes are only taken while a digit is lit.
   always_comb begin
      next_state = state;
      ready      = 1'b0;
      show_last  = 1'b0;
      tick       = 1'b0;
      case (state)
         BLANK: begin
            next_state = SHOW;
         end
         SHOW: begin
            ready = 1'b1;
            if (dwell_cnt == '0) begin
               show_last  = 1'b1;
               next_state = BLANK;
               tick       = (idx == LAST_IDX);
            end
         end
         default: begin
            next_state = BLANK;
         end
      endcase
   end

   // Digit datapath: latch glyph and select leaving BLANK, clear them leaving SHOW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= '0;
         dwell_cnt <= '0;
         sel       <= '0;
         segm      <= '0;
      end else if (state == BLANK) begin
         segm      <= glyph14(rd_char);
         sel       <= NUM_DIGITS'(1) << idx;
         dwell_cnt <= dwell_load;
      end else if (show_last) begin
         segm <= '0;
         sel  <= '0;
         idx  <= (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
      end else begin
         dwell_cnt <= dwell_cnt - DWELL_W'(1);
      end
   end

   // Scroll position: disabling scroll wins over a coincident frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         offset    <= '0;
         frame_cnt <= '0;
      end else if (!scroll_en) begin
         offset    <= '0;
         frame_cnt <= '0;
      end else if (tick) begin
         if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            offset    <= (offset == LAST_IDX) ? '0 : offset + ADDR_W'(1);
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Flag a consumed write whose slot address does not exist, one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else begin
         err <= accept && addr_bad;
      end
   end

endmodule

// File: tb/tb_seg14_scan_ctrl.sv
// Directed bench for seg14_scan_ctrl: scan timing, glyph rendering, write
// handshake and error pulse, scrolling, dwell handling and asynchronous reset.
module tb_seg14_scan_ctrl;
   import seg14_pkg::*;

   localparam logic [13:0] G_A = 14'b11101111000000;
   localparam logic [13:0] G_C = 14'b10011100000000;
   localparam logic [13:0] G_H = 14'b01101111000000;
   localparam logic [13:0] G_M = 14'b01101100101000;
   localparam logic [13:0] G_O = 14'b11111100000000;

   logic        clk;
   logic        rst_n;
   logic [15:0] dwell_cfg;
   logic        scroll_en;
   logic [11:0] sel;
   logic [13:0] segm;
   logic        frame_tick;

   int total;
   int bad;

   logic [13:0] msg_seg [12];
   logic [13:0] exp_seg [12];
   logic [13:0] cap     [12];
   logic [11:0] seen;
   int          rdy_bad;
   int          frame_bad;
   int          cap_len;

   seg14_scan_ctrl_if wif ();

   seg14_scan_ctrl #(
      .NUM_DIGITS    (12),
      .DWELL_W       (16),
      .SCROLL_FRAMES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dwell_cfg  (dwell_cfg),
      .wr         (wif.slave),
      .scroll_en  (scroll_en),
      .sel        (sel),
      .segm       (segm),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_exp(input int off);
      for (int k = 0; k < 12; k++) exp_seg[k] = msg_seg[(k + off) % 12];
   endtask

   task automatic wait_ticks(input int n);
      for (int t = 0; t < n; t++) begin
         bit got;
         got = 0;
         for (int c = 0; c < 5000 && !got; c++) begin
            @(negedge clk);
            if (frame_tick) got = 1;
         end
         if (!got) begin
            total++;
            bad++;
            $display("FAIL wait_ticks: frame_tick=0 after 5000 cycles, required 1");
         end
      end
   endtask

   // Records the segment pattern shown on each digit over one frame, ending on frame_tick.
   task automatic capture();
      bit done;
      done    = 0;
      seen    = '0;
      rdy_bad = 0;
      cap_len = 0;
      for (int k = 0; k < 12; k++) cap[k] = '0;
      for (int n = 0; n < 3000 && !done; n++) begin
         @(negedge clk);
         cap_len++;
         if (sel == '0) begin
            if (wif.wr_ready !== 1'b0) rdy_bad++;
         end else begin
            if (wif.wr_ready !== 1'b1) rdy_bad++;
            for (int k = 0; k < 12; k++) begin
               if (sel[k]) begin
                  cap[k]  = segm;
                  seen[k] = 1'b1;
               end
            end
         end
         if (frame_tick) done = 1;
      end
      frame_bad = 0;
      for (int k = 0; k < 12; k++) begin
         if (!seen[k] || cap[k] !== exp_seg[k]) frame_bad++;
      end
   endtask

   task automatic do_write(input logic [3:0] a, input logic [5:0] c, output bit ok, output logic err);
      ok = 0;
      @(negedge clk);
      wif.wr_valid = 1'b1;
      wif.wr_addr  = a;
      wif.wr_char  = c;
      for (int n = 0; n < 100; n++) begin
         if (wif.wr_ready) begin
            ok = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      err = wif.wr_err;
      wif.wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      dwell_cfg    = 16'd3;
      scroll_en    = 1'b0;
      wif.wr_valid = 1'b0;
      wif.wr_addr  = '0;
      wif.wr_char  = '0;
      repeat (3) @(negedge clk);
      total++; if (sel !== 12'h000) begin bad++; $display("FAIL reset_sel: got %h want 000", sel); end
      total++; if (segm !== 14'h0) begin bad++; $display("FAIL reset_segm: got %b want 0", segm); end
      total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", wif.wr_ready); end
      total++; if (wif.wr_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", wif.wr_err); end
      total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
   endtask

   // Two frames with an empty buffer and D=3: 1 blank cycle then 3 lit cycles per digit.
   task automatic test_blank_scan();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 96; i++) begin
         int          p;
         int          k;
         logic [11:0] es;
         logic        et;
         p  = i % 4;
         k  = (i % 48) / 4;
         es = (p == 0) ? 12'h000 : (12'h001 << k);
         et = (k == 11) && (p == 3);
         total++;
         if ({sel, segm, frame_tick, wif.wr_ready} !== {es, 14'h0, et, (p != 0)}) begin
            bad++;
            $display("FAIL scan cycle %0d: sel=%h segm=%b tick=%b ready=%b, want sel=%h segm=0 tick=%b ready=%b",
                     i, sel, segm, frame_tick, wif.wr_ready, es, et, (p != 0));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_message();
      logic [5:0] codes [7];
      bit         ok;
      logic       err;
      codes = '{6'd3, 6'd1, 6'd13, 6'd1, 6'd3, 6'd8, 6'd15};
      dwell_cfg = 16'd2;
      for (int s = 0; s < 7; s++) begin
         do_write(4'(s), codes[s], ok, err);
         total++; if (!ok) begin bad++; $display("FAIL msg_write slot %0d: accepted=0 want 1", s); end
         total++; if (err !== 1'b0) begin bad++; $display("FAIL msg_write_err slot %0d: got %b want 0", s, err); end
      end
      wait_ticks(1);
      set_exp(0);
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL message frame: bad slots=%0d want 0", frame_bad); end
      total++; if (rdy_bad !== 0) begin bad++; $display("FAIL message ready: bad cycles=%0d want 0", rdy_bad); end
      total++; if (cap_len !== 36) begin bad++; $display("FAIL message frame_len: got %0d want 36", cap_len); end
   endtask

   task automatic test_wr_err();
      bit   ok;
      logic err;
      bit   found;
      do_write(4'd12, 6'd5, ok, err);
      total++; if (!ok) begin bad++; $display("FAIL err_accept: accepted=0 want 1"); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b want 1", err); end
      @(negedge clk);
      total++; if (wif.wr_err !== 1'b0) begin bad++; $display("FAIL err_pulse_end: got %b want 0", wif.wr_err); end
      // A request raised during a blanking cycle must wait for the lit cycle.
      found = 0;
      for (int n = 0; n < 50 && !found; n++) begin
         @(negedge clk);
         if (sel == 12'h000) found = 1;
      end
      total++; if (!found) begin bad++; $display("FAIL stall_find_blank: blank=0 want 1"); end
      wif.wr_valid = 1'b1;
      wif.wr_addr  = 4'd13;
      wif.wr_char  = 6'd7;
      total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL stall_blank_ready: got %b want 0", wif.wr_ready); end
      @(negedge clk);
      total++; if (wif.wr_ready !== 1'b1) begin bad++; $display("FAIL stall_show_ready: got %b want 1", wif.wr_ready); end
      total++; if (wif.wr_err !== 1'b0) begin bad++; $display("FAIL stall_no_accept: err=%b want 0", wif.wr_err); end
      @(negedge clk);
      total++; if (wif.wr_err !== 1'b1) begin bad++; $display("FAIL stall_accept: err=%b want 1", wif.wr_err); end
      wif.wr_valid = 1'b0;
      @(negedge clk);
      total++; if (wif.wr_err !== 1'b0) begin bad++; $display("FAIL stall_err_end: got %b want 0", wif.wr_err); end
      wait_ticks(1);
      set_exp(0);
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL err_buffer_unchanged: bad slots=%0d want 0", frame_bad); end
      total++; if (rdy_bad !== 0) begin bad++; $display("FAIL err_ready: bad cycles=%0d want 0", rdy_bad); end
   endtask

   task automatic test_scroll();
      @(negedge clk);
      scroll_en = 1'b1;
      wait_ticks(2);
      set_exp(1);
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL scroll_off1: bad slots=%0d want 0", frame_bad); end
      total++; if (cap[0] !== G_A) begin bad++; $display("FAIL scroll_digit0: got %b want %b", cap[0], G_A); end
      wait_ticks(19);
      set_exp(11);
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL scroll_off11: bad slots=%0d want 0", frame_bad); end
      wait_ticks(1);
      set_exp(0);
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL scroll_wrap: bad slots=%0d want 0", frame_bad); end
      // A one-cycle drop of scroll_en must restart the frame count.
      @(negedge clk);
      scroll_en = 1'b0;
      @(negedge clk);
      scroll_en = 1'b1;
      wait_ticks(1);
      set_exp(0);
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL scroll_cnt_clear: bad slots=%0d want 0", frame_bad); end
      @(negedge clk);
      scroll_en = 1'b0;
      wait_ticks(1);
      set_exp(0);
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL scroll_off_clear: bad slots=%0d want 0", frame_bad); end
   endtask

   task automatic test_dwell();
      bit found;
      int cnt;
      dwell_cfg = 16'd0;
      wait_ticks(2);
      set_exp(0);
      capture();
      total++; if (cap_len !== 24) begin bad++; $display("FAIL dwell0_frame_len: got %0d want 24", cap_len); end
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL dwell0_frame: bad slots=%0d want 0", frame_bad); end
      dwell_cfg = 16'd1;
      wait_ticks(2);
      found = 0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk);
         if (sel == 12'h008) found = 1;
      end
      total++; if (!found) begin bad++; $display("FAIL dwell_find_digit3: seen=0 want 1"); end
      dwell_cfg = 16'd5;
      @(negedge clk);
      total++; if (sel !== 12'h000) begin bad++; $display("FAIL dwell_current_unaffected: sel=%h want 000", sel); end
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (sel == 12'h010) cnt++;
         else if (cnt > 0) break;
      end
      total++; if (cnt !== 5) begin bad++; $display("FAIL dwell_next_digit: lit %0d cycles want 5", cnt); end
   endtask

   task automatic test_reset_mid();
      bit   found;
      bit   ok;
      logic err;
      found = 0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (sel == 12'h001) found = 1;
      end
      total++; if (!found) begin bad++; $display("FAIL rstmid_find_digit0: seen=0 want 1"); end
      total++; if (segm !== G_C) begin bad++; $display("FAIL rstmid_before: segm=%b want %b", segm, G_C); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (sel !== 12'h000) begin bad++; $display("FAIL rstmid_sel: got %h want 000", sel); end
      total++; if (segm !== 14'h0) begin bad++; $display("FAIL rstmid_segm: got %b want 0", segm); end
      total++; if (wif.wr_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got %b want 0", wif.wr_ready); end
      @(negedge clk);
      rst_n     = 1'b1;
      dwell_cfg = 16'd2;
      wait_ticks(1);
      for (int k = 0; k < 12; k++) exp_seg[k] = '0;
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL rstmid_buffer_clear: bad slots=%0d want 0", frame_bad); end
      do_write(4'd0, 6'd50, ok, err);
      total++; if (!ok) begin bad++; $display("FAIL rstmid_write50: accepted=0 want 1"); end
      do_write(4'd1, 6'd1, ok, err);
      total++; if (!ok) begin bad++; $display("FAIL rstmid_writeA: accepted=0 want 1"); end
      wait_ticks(1);
      exp_seg[1] = G_A;
      capture();
      total++; if (frame_bad !== 0) begin bad++; $display("FAIL rstmid_code50_blank: bad slots=%0d want 0", frame_bad); end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      msg_seg = '{G_C, G_A, G_M, G_A, G_C, G_H, G_O, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0};
      test_reset();
      test_blank_scan();
      test_message();
      test_wr_err();
      test_scroll();
      test_dwell();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
